// File: rtl/pipe_shifter_pkg.sv
// Shared types for the pipelined barrel shifter: shift-mode enum and per-rank payload.
// The optional carry output is enabled by defining PIPE_SHIFTER_CARRY_EN.
package shifter_pkg;

    localparam int SH_MAX_B = 7;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } sh_mode_e;

    // Control fields that ride alongside the data through every rank
    typedef struct packed {
        sh_mode_e              mode;
        logic [SH_MAX_B-1:0]   sh;
    } sh_payload_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/pipe_shifter_if.sv
// Valid/ready bus of the pipelined shifter; carry exists only under PIPE_SHIFTER_CARRY_EN.
interface pipe_shifter_if #(
    parameter int N = 32,
    parameter int B = $clog2(N)
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] num;
    logic [B-1:0] shift_num;
    logic [1:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out;
    logic         zero;
`ifdef PIPE_SHIFTER_CARRY_EN
    logic         carry;

    modport master (output in_valid, num, shift_num, mode, out_ready,
                    input  in_ready, out_valid, out, zero, carry);
    modport slave  (input  in_valid, num, shift_num, mode, out_ready,
                    output in_ready, out_valid, out, zero, carry);
`else
    modport master (output in_valid, num, shift_num, mode, out_ready,
                    input  in_ready, out_valid, out, zero);
    modport slave  (input  in_valid, num, shift_num, mode, out_ready,
                    output in_ready, out_valid, out, zero);
`endif
endinterface

// File: rtl/pipe_shifter_shift_level.sv
// One barrel-shifter mux level: shifts/rotates by 2^K when enabled, for all four modes.
// Carry tracking (last bit shifted out) is present only under PIPE_SHIFTER_CARRY_EN.
module shift_level
    import shifter_pkg::*;
#(
    parameter int N = 32,
    parameter int K = 0
) (
    input  logic [N-1:0] i_data,
    input  sh_mode_e     i_mode,
    input  logic         i_en,
`ifdef PIPE_SHIFTER_CARRY_EN
    input  logic         i_carry,
    output logic         o_carry,
`endif
    output logic [N-1:0] o_data
);
    localparam int S = 1 << K;

    logic signed [N-1:0] w_sdata;
    assign w_sdata = i_data;

    always_comb begin
        o_data = i_data;
        if (i_en) begin
            case (i_mode)
                SH_LSL:  o_data = i_data << S;
                SH_LSR:  o_data = i_data >> S;
                SH_ASR:  o_data = w_sdata >>> S;
                SH_ROR:  o_data = {i_data[S-1:0], i_data[N-1:S]};
                default: o_data = i_data;
            endcase
        end
    end

`ifdef PIPE_SHIFTER_CARRY_EN
    // A later level that does not shift leaves the carry of the last shifting level in place
    always_comb begin
        o_carry = i_carry;
        if (i_en) begin
            case (i_mode)
                SH_LSL:  o_carry = i_data[N-S];
                default: o_carry = i_data[S-1];
            endcase
        end
    end
`endif

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR) with per-rank valid bits and bubble collapse.
// Define PIPE_SHIFTER_CARRY_EN to add the carry output and its per-rank storage.
module pipe_shifter
    import shifter_pkg::*;
#(
    parameter int N      = 32,
    parameter int B      = $clog2(N),
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_shifter_if.slave bus
);
    localparam int G = ceil_div(B, STAGES);

    logic [STAGES-1:0] r_vld;
    logic [N-1:0]      r_data [STAGES];
    sh_payload_t       r_ctl  [STAGES];

    logic [STAGES-1:0] w_ld;
    logic [STAGES-1:0] w_src_vld;
    logic [N-1:0]      w_src_data [STAGES];
    sh_payload_t       w_src_ctl  [STAGES];
    logic [N-1:0]      w_grp_data [STAGES];
    logic [N-1:0]      w_lvl_data [B];
    logic [N-1:0]      w_out;
`ifdef PIPE_SHIFTER_CARRY_EN
    logic [STAGES-1:0] r_carry;
    logic [STAGES-1:0] w_src_carry;
    logic [STAGES-1:0] w_grp_carry;
    logic [B-1:0]      w_lvl_carry;
`endif

    genvar r, i;
    for (r = 0; r < STAGES; r++) begin : g_rank
        localparam int LAST = (((r + 1) * G < B) ? (r + 1) * G : B) - 1;

        // A rank advances unless it and every rank downstream are full and the sink is stalled
        assign w_ld[r] = bus.out_ready || !(&r_vld[STAGES-1:r]);

        if (r == 0) begin : g_head
            assign w_src_vld[0]  = bus.in_valid;
            assign w_src_data[0] = bus.num;
            assign w_src_ctl[0]  = '{mode: sh_mode_e'(bus.mode), sh: SH_MAX_B'(bus.shift_num)};
`ifdef PIPE_SHIFTER_CARRY_EN
            assign w_src_carry[0] = 1'b0;
`endif
        end else begin : g_body
            assign w_src_vld[r]  = r_vld[r-1];
            assign w_src_data[r] = r_data[r-1];
            assign w_src_ctl[r]  = r_ctl[r-1];
`ifdef PIPE_SHIFTER_CARRY_EN
            assign w_src_carry[r] = r_carry[r-1];
`endif
        end

        if (r * G >= B) begin : g_pass
            assign w_grp_data[r] = w_src_data[r];
`ifdef PIPE_SHIFTER_CARRY_EN
            assign w_grp_carry[r] = w_src_carry[r];
`endif
        end else begin : g_tail
            assign w_grp_data[r] = w_lvl_data[LAST];
`ifdef PIPE_SHIFTER_CARRY_EN
            assign w_grp_carry[r] = w_lvl_carry[LAST];
`endif
        end
    end

    for (i = 0; i < B; i++) begin : g_lvl
        localparam int R = i / G;
        localparam int K = B - 1 - i;
        logic [N-1:0] w_in;
`ifdef PIPE_SHIFTER_CARRY_EN
        logic         w_cin;
`endif
        if (i % G == 0) begin : g_first
            assign w_in = w_src_data[R];
`ifdef PIPE_SHIFTER_CARRY_EN
            assign w_cin = w_src_carry[R];
`endif
        end else begin : g_chain
            assign w_in = w_lvl_data[i-1];
`ifdef PIPE_SHIFTER_CARRY_EN
            assign w_cin = w_lvl_carry[i-1];
`endif
        end

        shift_level #(.N(N), .K(K)) u_lvl (
            .i_data  (w_in),
            .i_mode  (w_src_ctl[R].mode),
            .i_en    (w_src_ctl[R].sh[K]),
`ifdef PIPE_SHIFTER_CARRY_EN
            .i_carry (w_cin),
            .o_carry (w_lvl_carry[i]),
`endif
            .o_data  (w_lvl_data[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ld[k]) r_vld[k] <= w_src_vld[k];
            end
        end
    end

    // Payload needs no reset: outputs are masked by the valid bit
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (w_ld[k]) begin
                r_data[k]  <= w_grp_data[k];
                r_ctl[k]   <= w_src_ctl[k];
`ifdef PIPE_SHIFTER_CARRY_EN
                r_carry[k] <= w_grp_carry[k];
`endif
            end
        end
    end

    assign w_out         = r_vld[STAGES-1] ? r_data[STAGES-1] : '0;
    assign bus.out       = w_out;
    assign bus.zero      = (w_out == '0);
    assign bus.out_valid = r_vld[STAGES-1];
    assign bus.in_ready  = w_ld[0];
`ifdef PIPE_SHIFTER_CARRY_EN
    assign bus.carry     = r_vld[STAGES-1] & r_carry[STAGES-1];
`endif

endmodule

// File: tb/tb_pipe_shifter.sv
// Directed bench for pipe_shifter at N=32 with STAGES = 2, 1 and 5 instances side by side.
// Carry checks are compiled in when PIPE_SHIFTER_CARRY_EN is defined.
module tb_pipe_shifter;
    localparam int N  = 32;
    localparam int SA = 2;
    localparam int SB = 1;
    localparam int SC = 5;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    pipe_shifter_if #(.N(N)) if_a ();
    pipe_shifter_if #(.N(N)) if_b ();
    pipe_shifter_if #(.N(N)) if_c ();

    pipe_shifter #(.N(N), .STAGES(SA)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    pipe_shifter #(.N(N), .STAGES(SB)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    pipe_shifter #(.N(N), .STAGES(SC)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] n, input int sh, input int m);
        if_a.in_valid = v; if_a.num = n; if_a.shift_num = 5'(sh); if_a.mode = 2'(m);
        if_b.in_valid = v; if_b.num = n; if_b.shift_num = 5'(sh); if_b.mode = 2'(m);
        if_c.in_valid = v; if_c.num = n; if_c.shift_num = 5'(sh); if_c.mode = 2'(m);
    endtask

    task automatic set_ordy(input logic rdy);
        if_a.out_ready = rdy;
        if_b.out_ready = rdy;
        if_c.out_ready = rdy;
    endtask

    // Bitwise reference: each output bit picks its source bit directly
    function automatic logic [32:0] ref_shift(input logic [31:0] a, input int sh, input int m);
        logic [31:0] res;
        logic        c;
        for (int k = 0; k < 32; k++) begin
            case (m)
                0:       res[k] = (k >= sh) ? a[k-sh] : 1'b0;
                1:       res[k] = (k + sh < 32) ? a[k+sh] : 1'b0;
                2:       res[k] = (k + sh < 32) ? a[k+sh] : a[31];
                default: res[k] = a[(k+sh)%32];
            endcase
        end
        if (sh == 0)     c = 1'b0;
        else if (m == 0) c = a[32-sh];
        else if (m == 3) c = res[31];
        else             c = a[sh-1];
        return {c, res};
    endfunction

    task automatic run_vec(input string tag, input logic [31:0] n, input int sh, input int m,
                           input logic [31:0] e_out, input logic e_c);
        set_in(1'b1, n, sh, m);
        #1;
        check({tag, ".in_ready"}, 32'(if_a.in_ready), 32'd1);
        tick();
        set_in(1'b0, 32'd0, 0, 0);
        check({tag, ".b_out"}, if_b.out, e_out);
        check({tag, ".a_early_valid"}, 32'(if_a.out_valid), 32'd0);
        tick();
        check({tag, ".a_valid"}, 32'(if_a.out_valid), 32'd1);
        check({tag, ".a_out"}, if_a.out, e_out);
        check({tag, ".a_zero"}, 32'(if_a.zero), 32'(e_out == 32'd0));
`ifdef PIPE_SHIFTER_CARRY_EN
        check({tag, ".a_carry"}, 32'(if_a.carry), 32'(e_c));
`endif
        repeat (3) tick();
        check({tag, ".c_valid"}, 32'(if_c.out_valid), 32'd1);
        check({tag, ".c_out"}, if_c.out, e_out);
`ifdef PIPE_SHIFTER_CARRY_EN
        check({tag, ".c_carry"}, 32'(if_c.carry), 32'(e_c));
`else
        if (e_c === 1'bx) check({tag, ".carry_x"}, 32'd0, 32'd1);
`endif
    endtask

    logic [31:0] s_num [20];
    int          s_sh  [20];
    int          s_m   [20];
    int          sent, got, inflight;
    logic        ordy, acc, drn, stall_prev, prev_c;
    logic [31:0] prev_out;
    logic [32:0] exp_r;
    logic        seen_a, seen_b, seen_c;

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 32'd0, 0, 0);
        set_ordy(1'b1);
        #2;
        check("rst.a_valid", 32'(if_a.out_valid), 32'd0);
        check("rst.a_out", if_a.out, 32'd0);
        check("rst.a_zero", 32'(if_a.zero), 32'd1);
        check("rst.c_valid", 32'(if_c.out_valid), 32'd0);
`ifdef PIPE_SHIFTER_CARRY_EN
        check("rst.a_carry", 32'(if_a.carry), 32'd0);
`endif
        #10 rst_n = 1'b1;
        tick();
        check("rst.a_in_ready", 32'(if_a.in_ready), 32'd1);

        run_vec("lsl31",  32'h0000_0001, 31, 0, 32'h8000_0000, 1'b0);
        run_vec("asr4",   32'h8000_0000,  4, 2, 32'hF800_0000, 1'b0);
        run_vec("lsr2",   32'h0000_000F,  2, 1, 32'h0000_0003, 1'b1);
        run_vec("ror4",   32'h0000_00F1,  4, 3, 32'h1000_000F, 1'b0);
        run_vec("lsl1",   32'h8000_0000,  1, 0, 32'h0000_0000, 1'b1);
        run_vec("asr0",   32'h8000_0001,  0, 2, 32'h8000_0001, 1'b0);
        run_vec("ror1",   32'h0000_0001,  1, 3, 32'h8000_0000, 1'b1);
        run_vec("lsr31",  32'hFFFF_FFFF, 31, 1, 32'h0000_0001, 1'b1);

        // Stream of 20 ops on the STAGES=2 instance with a 5-cycle sink stall
        for (int k = 0; k < 20; k++) begin
            s_num[k] = $urandom;
            s_sh[k]  = $urandom_range(0, 31);
            s_m[k]   = $urandom_range(0, 3);
        end
        sent = 0; got = 0; inflight = 0; stall_prev = 1'b0;
        prev_out = 32'd0; prev_c = 1'b0;
        for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
            ordy = !(cyc >= 8 && cyc < 13);
            set_ordy(ordy);
            if (sent < 20) set_in(1'b1, s_num[sent], s_sh[sent], s_m[sent]);
            else           set_in(1'b0, 32'd0, 0, 0);
            #1;
            if (stall_prev) begin
                check("s.hold_valid", 32'(if_a.out_valid), 32'd1);
                check("s.hold_out", if_a.out, prev_out);
`ifdef PIPE_SHIFTER_CARRY_EN
                check("s.hold_carry", 32'(if_a.carry), 32'(prev_c));
`endif
            end
            check("s.in_ready", 32'(if_a.in_ready), 32'(ordy || (inflight < SA)));
            acc = if_a.in_valid && if_a.in_ready;
            drn = if_a.out_valid && ordy;
            if (drn) begin
                exp_r = ref_shift(s_num[got], s_sh[got], s_m[got]);
                check("s.out", if_a.out, exp_r[31:0]);
`ifdef PIPE_SHIFTER_CARRY_EN
                check("s.carry", 32'(if_a.carry), 32'(exp_r[32]));
`endif
                got++;
            end
            stall_prev = if_a.out_valid && !ordy;
            prev_out   = if_a.out;
`ifdef PIPE_SHIFTER_CARRY_EN
            prev_c     = if_a.carry;
`endif
            tick();
            if (acc) begin sent++; inflight++; end
            if (drn) inflight--;
        end
        check("s.count", 32'(got), 32'd20);

        set_in(1'b0, 32'd0, 0, 0);
        set_ordy(1'b1);
        repeat (8) tick();

        // Fill all instances under backpressure, then reset mid-flight
        set_ordy(1'b0);
        set_in(1'b1, 32'hA5A5_0001, 3, 0);
        repeat (5) tick();
        set_in(1'b0, 32'd0, 0, 0);
        check("mr.a_full_valid", 32'(if_a.out_valid), 32'd1);
        check("mr.b_full_valid", 32'(if_b.out_valid), 32'd1);
        check("mr.c_full_valid", 32'(if_c.out_valid), 32'd1);
        check("mr.a_in_ready", 32'(if_a.in_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("mr.a_valid", 32'(if_a.out_valid), 32'd0);
        check("mr.b_valid", 32'(if_b.out_valid), 32'd0);
        check("mr.c_valid", 32'(if_c.out_valid), 32'd0);
        check("mr.a_out", if_a.out, 32'd0);
        check("mr.c_out", if_c.out, 32'd0);
        check("mr.b_zero", 32'(if_b.zero), 32'd1);
`ifdef PIPE_SHIFTER_CARRY_EN
        check("mr.c_carry", 32'(if_c.carry), 32'd0);
`endif
        set_ordy(1'b1);
        #2 rst_n = 1'b1;
        tick();
        check("mr.a_in_ready", 32'(if_a.in_ready), 32'd1);
        check("mr.b_in_ready", 32'(if_b.in_ready), 32'd1);
        check("mr.c_in_ready", 32'(if_c.in_ready), 32'd1);
        seen_a = 1'b0; seen_b = 1'b0; seen_c = 1'b0;
        for (int k = 0; k < 10; k++) begin
            seen_a = seen_a | if_a.out_valid;
            seen_b = seen_b | if_b.out_valid;
            seen_c = seen_c | if_c.out_valid;
            tick();
        end
        check("mr.a_stale", 32'(seen_a), 32'd0);
        check("mr.b_stale", 32'(seen_b), 32'd0);
        check("mr.c_stale", 32'(seen_c), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_shifter.md
PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 Parameter N, default 32, operand width in bits; SHALL be a power of two, 8 to 128.
REQ-002 Parameter B, default $clog2(N), shift-amount width; derived, SHALL NOT be overridden.
REQ-003 Parameter STAGES, default 2, number of pipeline register ranks; legal range 1..B.
REQ-004 clk  input  1  single clock; all state rises on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  source presents an operation.
REQ-007 in_ready  output  1  block accepts the operation this cycle.
REQ-008 num  input  N  operand.
REQ-009 shift_num  input  B  shift amount, 0..N-1.
REQ-010 mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  sink accepts the result.
REQ-013 out  output  N  shifted/rotated result.
REQ-014 zero  output  1  out == 0.
REQ-015 carry  output  1  last bit shifted out (present only under PIPE_SHIFTER_CARRY_EN).

Function
REQ-016 Transfer occurs on a cycle where valid and ready are both high; in and out handshakes are independent.
REQ-017 LSL fills with 0; LSR fills with 0; ASR fills with num[N-1]; ROR wraps bits from LSB to MSB.
REQ-018 shift_num = 0 SHALL give out = num and carry = 0 in every mode.
REQ-019 Carry: LSL num[N-sh]; LSR/ASR num[sh-1]; ROR out[N-1]; sh = 0 gives 0.
REQ-020 The B mux levels (2^k-bit shift, k = B-1 down to 0) SHALL be split into STAGES groups of ceil(B/STAGES) levels, with a register rank after each group.
REQ-021 Latency: result appears on out exactly STAGES cycles after acceptance when out_ready stays high.
REQ-022 Throughput: one operation per cycle with no bubbles while out_ready is high.
REQ-023 Each rank holds a valid bit; rank k loads when empty or when rank k+1 loads or drains, so bubbles collapse under backpressure.
REQ-024 in_ready = rank 0 empty or rank 0 advancing; combinational path from out_ready to in_ready is permitted.
REQ-025 out, zero and carry SHALL hold stable while out_valid && !out_ready.
REQ-026 Operations SHALL leave in acceptance order; none dropped or duplicated.
REQ-027 Mode and shift_num travel with their data through every rank.
REQ-028 Full pipeline with out_ready low: in_ready low; out_ready rising releases one result and admits one input in the same cycle.

Reset
REQ-029 On rst_n low, all valid bits clear immediately; out_valid = 0, out = 0, zero = 1, carry = 0.
REQ-030 in_ready SHALL be 1 from the first clk edge after rst_n deasserts.
REQ-031 Reset mid-operation discards all in-flight operations; no result emerges afterwards.

Configuration
REQ-032 Macro PIPE_SHIFTER_CARRY_EN: when defined, carry port and its per-rank storage exist per REQ-019.
REQ-033 Without PIPE_SHIFTER_CARRY_EN, carry port and logic are absent; all other behaviour is identical.

Structure
REQ-034 Package shifter_pkg holds the mode enum (SH_LSL, SH_LSR, SH_ASR, SH_ROR) and the per-rank payload struct.
REQ-035 One sub-module shift_level: one 2^k mux level for all four modes, parametrised by N and k.

Verification
REQ-036 N=32, LSL, num 0x00000001, sh 31 -> out 0x80000000, carry 0, zero 0, after STAGES cycles.
REQ-037 ASR, num 0x80000000, sh 4 -> out 0xF8000000, carry 0; LSR, num 0x0000000F, sh 2 -> out 0x00000003, carry 1.
REQ-038 ROR, num 0x000000F1, sh 4 -> out 0x1000000F, carry 0; LSL, num 0x80000000, sh 1 -> out 0, zero 1, carry 1.
REQ-039 Stream 20 random ops, out_ready low for 5 cycles mid-stream -> all 20 results in order, in_ready low once full, outputs stable while stalled.
REQ-040 Pulse rst_n low with STAGES ops in flight -> out_valid drops immediately, no stale result after release; repeat for STAGES = 1 and B.
